// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the shared serial binary-to-BCD converter.
package bcd_conv_sched_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int OPERAND_W  = 8;
  localparam int ACC_W      = BCD_DIGITS * DIGIT_W;

  // Digits at or above this value are corrected by +3 before each shift
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_conv_sched_dabble_step.sv
// One double-dabble step: add-3 correction on each BCD digit, then shift in one bit.
module bcd_dabble_step
  import bcd_conv_sched_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic             bit_i,
  output logic [ACC_W-1:0] acc_o
);

  // The hundreds digit never exceeds 2 for 8-bit operands, so its MSB is shifted out unused
  logic [ACC_W-2:0] adj;

  // Correct every digit >= 5, then shift left with the new operand bit at the bottom
  always_comb begin
    adj = acc_i[ACC_W-2:0];
    for (int d = 0; d < BCD_DIGITS - 1; d++) begin
      if (acc_i[d*DIGIT_W +: DIGIT_W] >= ADD3_THRESH)
        adj[d*DIGIT_W +: DIGIT_W] = acc_i[d*DIGIT_W +: DIGIT_W] + 4'd3;
    end
    if (acc_i[ACC_W-1 -: DIGIT_W] >= ADD3_THRESH)
      adj[ACC_W-2 -: DIGIT_W-1] = 3'(acc_i[ACC_W-1 -: DIGIT_W] + 4'd3);
    acc_o = {adj, bit_i};
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin shared binary-to-BCD converter: one request served at a time,
// converted serially one bit per clock, result returned with the requester ID.
//
// state    | meaning
// ST_IDLE  | waiting; grants the round-robin winner combinationally
// ST_SHIFT | 8 double-dabble steps, counter 7 down to 0
// ST_DONE  | one-cycle result-valid pulse
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [8*NUM_REQ-1:0]     binario_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [DIGIT_W-1:0]       centenas,
  output logic [DIGIT_W-1:0]       dezenas,
  output logic [DIGIT_W-1:0]       unidades
);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q;
  logic [OPERAND_W-1:0] opnd_q;
  logic [ACC_W-1:0]     acc_q, acc_nxt;
  logic [ID_W-1:0]      id_q, last_q, done_id_q;
  logic [DIGIT_W-1:0]   cen_q, dez_q, uni_q;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx, cand;
  logic [OPERAND_W-1:0] ops [NUM_REQ];

  // Unpack the per-requester operands
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) ops[k] = binario_in[k*OPERAND_W +: OPERAND_W];
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(last_q) + 1 + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  bcd_dabble_step u_step (
    .acc_i (acc_q),
    .bit_i (opnd_q[OPERAND_W-1]),
    .acc_o (acc_nxt)
  );

  // Next-state logic and combinational outputs
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_SHIFT;
          if (resetn) gnt = NUM_REQ'(1) << win_idx;
        end
      end
      ST_SHIFT: if (cnt_q == 3'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and serial datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      done_id_q <= '0;
      cen_q     <= '0;
      dez_q     <= '0;
      uni_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            opnd_q <= ops[win_idx];
            id_q   <= win_idx;
            last_q <= win_idx;
            acc_q  <= '0;
            cnt_q  <= 3'd7;
          end
        end
        ST_SHIFT: begin
          acc_q  <= acc_nxt;
          opnd_q <= {opnd_q[OPERAND_W-2:0], 1'b0};
          cnt_q  <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            cen_q     <= acc_nxt[3*DIGIT_W-1 -: DIGIT_W];
            dez_q     <= acc_nxt[2*DIGIT_W-1 -: DIGIT_W];
            uni_q     <= acc_nxt[DIGIT_W-1:0];
            done_id_q <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign done_id  = done_id_q;
  assign centenas = cen_q;
  assign dezenas  = dez_q;
  assign unidades = uni_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with two requesters.
module tb_bcd_conv_sched;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  req;
  logic [15:0] binario_in;
  logic [1:0]  gnt;
  logic        busy, done;
  logic [0:0]  done_id;
  logic [3:0]  centenas, dezenas, unidades;

  int tests = 0;
  int fails = 0;
  logic [11:0] prev_dig = 12'h000;

  bcd_conv_sched #(.NUM_REQ(2), .ID_W(1)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req        (req),
    .binario_in (binario_in),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .centenas   (centenas),
    .dezenas    (dezenas),
    .unidades   (unidades)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [7:0] val;
    logic [3:0] c, d, u;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = 2'b00;
    tick();
    tick();
    resetn = 1'b1;
    prev_dig = 12'h000;
  endtask

  // One request on requester id, expecting the given digits, 9-cycle latency and hold behaviour
  task automatic convert(input int id, input logic [7:0] v,
                         input logic [3:0] ec, input logic [3:0] ed, input logic [3:0] eu,
                         input string nm);
    int n;
    bit got;
    binario_in[8*id +: 8] = v;
    req[id] = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (gnt != 2'b00) begin
        got = 1'b1;
        break;
      end
      tick();
      #1;
    end
    chk({nm, "_gnt"}, int'(gnt), 1 << id);
    if (!got) begin
      req[id] = 1'b0;
      return;
    end
    chk({nm, "_hold_at_gnt"}, int'({centenas, dezenas, unidades}), int'(prev_dig));
    tick();
    req[id] = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      chk({nm, "_busy"}, int'(busy), 1);
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, 9);
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_busy_done"}, int'(busy), 1);
    chk({nm, "_id"}, int'(done_id), id);
    chk({nm, "_digits"}, int'({centenas, dezenas, unidades}), int'({ec, ed, eu}));
    prev_dig = {ec, ed, eu};
    tick();
    chk({nm, "_done_once"}, int'(done), 0);
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'd255, 4'd2, 4'd5, 4'd5};
    vecs[1] = '{1, 8'd0,   4'd0, 4'd0, 4'd0};
    vecs[2] = '{1, 8'd100, 4'd1, 4'd0, 4'd0};
    vecs[3] = '{0, 8'd42,  4'd0, 4'd4, 4'd2};
    vecs[4] = '{1, 8'd199, 4'd1, 4'd9, 4'd9};
    vecs[5] = '{0, 8'd9,   4'd0, 4'd0, 4'd9};
    vecs[6] = '{1, 8'd10,  4'd0, 4'd1, 4'd0};
    vecs[7] = '{0, 8'd128, 4'd1, 4'd2, 4'd8};

    resetn     = 1'b0;
    req        = 2'b00;
    binario_in = 16'h0000;
    tick();
    tick();
    req = 2'b11;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    req = 2'b00;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_id", int'(done_id), 0);
    chk("rst_digits", int'({centenas, dezenas, unidades}), 0);
    tick();
    resetn = 1'b1;
    tick();

    // Table-driven conversions
    for (int i = 0; i < 8; i++)
      convert(vecs[i].id, vecs[i].val, vecs[i].c, vecs[i].d, vecs[i].u, $sformatf("vec%0d", i));

    // Digits hold while idle
    repeat (5) tick();
    chk("idle_hold", int'({centenas, dezenas, unidades}), int'(prev_dig));

    // Both requesters continuously: r0,r1,r0 at cycles 0,10,20
    do_reset();
    binario_in = {8'd199, 8'd42};
    req = 2'b11;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      chk($sformatf("rr_gnt_c%0d", cyc), int'(gnt),
          (cyc % 10 == 0) ? (((cyc / 10) % 2 == 0) ? 1 : 2) : 0);
      if (cyc % 10 == 9) begin
        chk($sformatf("rr_done_c%0d", cyc), int'(done), 1);
        chk($sformatf("rr_id_c%0d", cyc), int'(done_id), (cyc / 10) % 2);
        chk($sformatf("rr_dig_c%0d", cyc), int'({centenas, dezenas, unidades}),
            ((cyc / 10) % 2 == 0) ? 12'h042 : 12'h199);
      end else begin
        chk($sformatf("rr_nodone_c%0d", cyc), int'(done), 0);
      end
      tick();
      if (cyc == 29) req = 2'b00;
    end
    prev_dig = 12'h042;
    tick();

    // Reset in the middle of a conversion
    do_reset();
    binario_in = {8'd0, 8'd42};
    req = 2'b01;
    #1;
    chk("mid_gnt", int'(gnt), 1);
    tick();
    req = 2'b00;
    repeat (4) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_id", int'(done_id), 0);
    chk("mid_digits", int'({centenas, dezenas, unidades}), 0);
    tick();
    tick();
    resetn = 1'b1;
    prev_dig = 12'h000;
    for (int k = 0; k < 12; k++) begin
      chk("mid_no_done", int'(done), 0);
      tick();
    end
    convert(0, 8'd42, 4'd0, 4'd4, 4'd2, "mid_rereq");

    // Requests raised outside IDLE are not granted until IDLE
    binario_in = {8'd13, 8'd77};
    req = 2'b01;
    #1;
    chk("late_gnt0", int'(gnt), 1);
    tick();
    req = 2'b00;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (cyc == 4) req[1] = 1'b1;
      if (cyc == 6) req[1] = 1'b0;
      if (cyc == 9) req[0] = 1'b1;
      #1;
      chk($sformatf("late_nognt_c%0d", cyc), int'(gnt), 0);
      if (cyc == 9) begin
        chk("late_done", int'(done), 1);
        chk("late_dig", int'({centenas, dezenas, unidades}), 12'h077);
      end
      tick();
    end
    #1;
    chk("late_gnt10", int'(gnt), 1);
    tick();
    req = 2'b00;
    repeat (8) tick();
    chk("late_done2", int'(done), 1);
    chk("late_id2", int'(done_id), 0);
    chk("late_dig2", int'({centenas, dezenas, unidades}), 12'h077);
    prev_dig = 12'h077;
    tick();

    // Exhaustive sweep on both requesters
    for (int id = 0; id < 2; id++) begin
      for (int v = 0; v < 256; v++) begin
        convert(id, 8'(v), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10),
                $sformatf("sw%0d_%0d", id, v));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
